spi_slave_core: RTL

//  Synthesizable SPI slave: consumes the serial stream driven by spi_master_bfm (sclk/mosi/ss),

---
 rtl/spi_slave_core.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/spi_slave_core.sv
// SPI slave: oversamples sclk/mosi/ss in the clk domain, deserializes words onto a valid/ready
// receive stream and serializes words taken from a valid/ready transmit stream onto miso.
module spi_slave_core #(
    parameter int                    DATA_WIDTH   = 16,
    parameter bit                    CLK_POLARITY = 1'b0,
    parameter bit                    CLK_PHASE    = 1'b0,
    parameter int                    SYNC_STAGES  = 2,
    parameter logic [DATA_WIDTH-1:0] TX_DEFAULT   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  ss,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  overrun,
    output logic                  underrun,
    output logic                  frame_err
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        ACTIVE    = 2'd2
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync, primed;
    logic                   sclk_d, ss_d;
    logic                   sclk_s, mosi_s, ss_s;
    logic                   lead, trail, ss_fall, ss_rise;
    logic                   active, start, sample_en, drive_en, load, shift, last;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_WIDTH-1:0]  rx_shift, tx_shift;
    logic                   done_p1;

    // input synchronizers; primed marks when the ss chain holds real pin samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= {SYNC_STAGES{CLK_POLARITY}};
            mosi_sync <= '0;
            ss_sync   <= '1;
            primed    <= '0;
            sclk_d    <= CLK_POLARITY;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            primed    <= {primed[SYNC_STAGES-2:0], 1'b1};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign ss_s    = ss_sync[SYNC_STAGES-1];
    assign lead    = (sclk_d == CLK_POLARITY) && (sclk_s != CLK_POLARITY);
    assign trail   = (sclk_d != CLK_POLARITY) && (sclk_s == CLK_POLARITY);
    assign ss_fall = ss_d && !ss_s;
    assign ss_rise = !ss_d && ss_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_IDLE: if (primed[SYNC_STAGES-1] && ss_s) state_next = IDLE;
            IDLE:      if (ss_fall) state_next = ACTIVE;
            ACTIVE:    if (ss_rise) state_next = IDLE;
            default:   state_next = WAIT_IDLE;
        endcase
    end

    // CPHA selects which sclk edge samples mosi and which one advances miso
    assign active    = (state == ACTIVE);
    assign start     = (state == IDLE) && ss_fall;
    assign sample_en = active && !ss_rise && (CLK_PHASE ? trail : lead);
    assign drive_en  = active && !ss_rise && (CLK_PHASE ? lead : trail);
    assign load      = (drive_en && (bit_cnt == '0)) || (!CLK_PHASE && start);
    assign shift     = drive_en && (bit_cnt != '0);
    assign last      = sample_en && (bit_cnt == LAST_BIT);

    assign tx_ready  = load && tx_valid;
    assign underrun  = load && !tx_valid;
    assign frame_err = active && ss_rise && (bit_cnt != '0);
    assign overrun   = done_p1 && rx_valid && !rx_ready;
    assign miso      = active && tx_shift[DATA_WIDTH-1];
    assign miso_oe   = active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            done_p1  <= 1'b0;
        end else begin
            done_p1 <= last;
            if (ss_rise || !active)
                bit_cnt <= '0;
            else if (sample_en)
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);
            if (sample_en)
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
            if (load)
                tx_shift <= tx_valid ? tx_data : TX_DEFAULT;
            else if (shift)
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // completed word is handed off one cycle after its last sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (done_p1 && (!rx_valid || rx_ready)) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

endmodule
